// File: rtl/hier_node_pkg.sv
// Shared types, defaults and the round-robin grant helper for hierarchy nodes.
// Imported by the arbiter and every fan-in node built on it.
package hier_node_pkg;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } lock_state_e;

    localparam int unsigned DefaultDataW = 32;
    localparam int unsigned DefaultCntW  = 16;
    localparam int unsigned MaxChildren  = 64;

    // One-hot grant to the first set request at or after ptr, wrapping modulo num.
    function automatic logic [MaxChildren-1:0] rr_grant(
        input logic [MaxChildren-1:0] req,
        input int unsigned            ptr,
        input int unsigned            num
    );
        logic [MaxChildren-1:0] grant;
        logic                   found;
        int unsigned            idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MaxChildren; k++) begin
            idx = ptr + k;
            if (idx >= num) begin
                idx = idx - num;
            end
            if ((k < num) && !found && req[idx[5:0]]) begin
                grant[idx[5:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/hier_rr_arbiter.sv
// Round-robin arbiter with an optional lock that pins the grant to one child.
// Produces a one-hot (or zero) grant vector and its binary index.
module hier_rr_arbiter
    import hier_node_pkg::*;
#(
    parameter int unsigned NUM_CHILDREN = 15,
    parameter int unsigned IDX_W        = $clog2(NUM_CHILDREN)
) (
    input  logic [NUM_CHILDREN-1:0] req,
    input  logic [IDX_W-1:0]        ptr,
    input  logic                    lock,
    input  logic [IDX_W-1:0]        lock_idx,
    output logic [NUM_CHILDREN-1:0] grant,
    output logic [IDX_W-1:0]        grant_idx
);

    logic [MaxChildren-1:0] rr_wide;
    logic                   unused_rr;

    assign rr_wide   = rr_grant(MaxChildren'(req), 32'(ptr), NUM_CHILDREN);
    assign unused_rr = ^rr_wide;

    always_comb begin
        grant = '0;
        if (lock) begin
            // Locked grant is independent of the locked child's own request.
            for (int i = 0; i < int'(NUM_CHILDREN); i++) begin
                grant[i] = (lock_idx == IDX_W'(i));
            end
        end else begin
            grant = rr_wide[NUM_CHILDREN-1:0];
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < int'(NUM_CHILDREN); i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/hier_fanin_node.sv
// Hierarchy fan-in node: merges child valid/ready streams into one registered
// upstream stream, tagging each beat with its source child index.
module hier_fanin_node
    import hier_node_pkg::*;
#(
    parameter int unsigned NUM_CHILDREN = 15,
    parameter int unsigned DATA_W       = DefaultDataW,
    parameter int unsigned LOCK_MODE    = 0,
    parameter int unsigned CNT_W        = DefaultCntW,
    parameter int unsigned IDX_W        = $clog2(NUM_CHILDREN)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CHILDREN-1:0]        s_valid,
    output logic [NUM_CHILDREN-1:0]        s_ready,
    input  logic [NUM_CHILDREN*DATA_W-1:0] s_data,
    input  logic [NUM_CHILDREN-1:0]        s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_W-1:0]              m_data,
    output logic                           m_last,
    output logic [IDX_W-1:0]               m_src,
    output logic [CNT_W-1:0]               xfer_cnt
);

    if ((NUM_CHILDREN < 2) || (NUM_CHILDREN > MaxChildren) ||
        ((NUM_CHILDREN - 1) >= (1 << IDX_W))) begin : g_bad_params
        $error("hier_fanin_node: NUM_CHILDREN out of range or IDX_W too narrow");
    end

    logic                    m_valid_q, m_valid_d;
    logic [DATA_W-1:0]       m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;
    logic [IDX_W-1:0]        m_src_q, m_src_d;
    logic [CNT_W-1:0]        xfer_cnt_q, xfer_cnt_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    lock_state_e             state_q, state_d;
    logic [IDX_W-1:0]        lock_idx_q, lock_idx_d;

    logic                    load_en;
    logic                    locked;
    logic                    child_hs;
    logic [NUM_CHILDREN-1:0] grant;
    logic [IDX_W-1:0]        grant_idx;
    logic [DATA_W-1:0]       sel_data;
    logic                    sel_last;

    assign locked = (state_q == StLocked);

    hier_rr_arbiter #(
        .NUM_CHILDREN (NUM_CHILDREN),
        .IDX_W        (IDX_W)
    ) u_arb (
        .req       (s_valid),
        .ptr       (ptr_q),
        .lock      (locked),
        .lock_idx  (lock_idx_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        load_en  = !m_valid_q || m_ready;
        s_ready  = (rst_n && load_en) ? grant : '0;
        child_hs = |(s_valid & s_ready);
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < int'(NUM_CHILDREN); i++) begin
            if (grant[i]) begin
                sel_data = s_data[i*DATA_W +: DATA_W];
                sel_last = s_last[i];
            end
        end
    end

    always_comb begin
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        m_src_d    = m_src_q;
        xfer_cnt_d = xfer_cnt_q;
        ptr_d      = ptr_q;
        state_d    = state_q;
        lock_idx_d = lock_idx_q;

        if (load_en) begin
            m_valid_d = child_hs;
        end

        if (child_hs) begin
            m_data_d = sel_data;
            m_last_d = sel_last;
            m_src_d  = grant_idx;
            ptr_d    = (grant_idx == IDX_W'(NUM_CHILDREN - 1)) ? '0 : grant_idx + IDX_W'(1);
            // Single-beat packets never lock; only a non-last first beat does.
            if (LOCK_MODE != 0) begin
                if (!locked && !sel_last) begin
                    state_d    = StLocked;
                    lock_idx_d = grant_idx;
                end else if (locked && sel_last) begin
                    state_d = StIdle;
                end
            end
        end

        if (m_valid_q && m_ready) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            m_src_q    <= '0;
            xfer_cnt_q <= '0;
            ptr_q      <= '0;
            state_q    <= StIdle;
            lock_idx_q <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            m_src_q    <= m_src_d;
            xfer_cnt_q <= xfer_cnt_d;
            ptr_q      <= ptr_d;
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign m_src    = m_src_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_hier_fanin_node.sv
// Directed bench for hier_fanin_node: an unlocked 4-bit-counter instance and a
// locked instance share the same child/upstream stimulus.
module tb_hier_fanin_node;

    localparam int unsigned N  = 15;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  s_valid;
    logic [N-1:0]  s_last;
    logic [N*DW-1:0] s_data;
    logic          m_ready;

    logic [N-1:0]  a_s_ready, b_s_ready;
    logic          a_m_valid, b_m_valid;
    logic [DW-1:0] a_m_data, b_m_data;
    logic          a_m_last, b_m_last;
    logic [3:0]    a_m_src, b_m_src;
    logic [3:0]    a_cnt;
    logic [15:0]   b_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hier_fanin_node #(
        .NUM_CHILDREN (N),
        .DATA_W       (DW),
        .LOCK_MODE    (0),
        .CNT_W        (4)
    ) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (a_s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (a_m_valid),
        .m_ready  (m_ready),
        .m_data   (a_m_data),
        .m_last   (a_m_last),
        .m_src    (a_m_src),
        .xfer_cnt (a_cnt)
    );

    hier_fanin_node #(
        .NUM_CHILDREN (N),
        .DATA_W       (DW),
        .LOCK_MODE    (1),
        .CNT_W        (16)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (b_s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (b_m_valid),
        .m_ready  (m_ready),
        .m_data   (b_m_data),
        .m_last   (b_m_last),
        .m_src    (b_m_src),
        .xfer_cnt (b_cnt)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic         mrdy;
        logic [N-1:0] exp_ready;
        logic         exp_mvalid;
        logic [3:0]   exp_src;
        logic [3:0]   exp_cnt;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = '0;
        s_last  = '1;
        m_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) begin
            s_data[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);
        end

        // Idle drain, pointer advance, backpressure, back-to-back loads.
        tbl[0]  = '{15'h0001, 1'b1, 15'h0001, 1'b1, 4'd0, 4'd0};
        tbl[1]  = '{15'h0000, 1'b1, 15'h0000, 1'b0, 4'd0, 4'd1};
        tbl[2]  = '{15'h0000, 1'b1, 15'h0000, 1'b0, 4'd0, 4'd1};
        tbl[3]  = '{15'h0003, 1'b1, 15'h0002, 1'b1, 4'd1, 4'd1};
        tbl[4]  = '{15'h0008, 1'b1, 15'h0008, 1'b1, 4'd3, 4'd2};
        tbl[5]  = '{15'h0008, 1'b0, 15'h0000, 1'b1, 4'd3, 4'd2};
        tbl[6]  = '{15'h0008, 1'b0, 15'h0000, 1'b1, 4'd3, 4'd2};
        tbl[7]  = '{15'h0008, 1'b0, 15'h0000, 1'b1, 4'd3, 4'd2};
        tbl[8]  = '{15'h0008, 1'b0, 15'h0000, 1'b1, 4'd3, 4'd2};
        tbl[9]  = '{15'h0000, 1'b1, 15'h0000, 1'b0, 4'd3, 4'd3};
        tbl[10] = '{15'h0030, 1'b1, 15'h0010, 1'b1, 4'd4, 4'd3};
        tbl[11] = '{15'h0030, 1'b1, 15'h0020, 1'b1, 4'd5, 4'd4};
        tbl[12] = '{15'h0030, 1'b1, 15'h0010, 1'b1, 4'd4, 4'd5};
        tbl[13] = '{15'h0000, 1'b1, 15'h0000, 1'b0, 4'd4, 4'd6};

        // Reset state, with every child requesting while held in reset.
        rst_n   = 1'b0;
        s_valid = '1;
        s_last  = '1;
        m_ready = 1'b1;
        tick();
        tick();
        chk("rst_s_ready_a", 64'(a_s_ready), 64'd0);
        chk("rst_s_ready_b", 64'(b_s_ready), 64'd0);
        chk("rst_m_valid", 64'(a_m_valid), 64'd0);
        chk("rst_m_data", 64'(a_m_data), 64'd0);
        chk("rst_m_last", 64'(a_m_last), 64'd0);
        chk("rst_m_src", 64'(a_m_src), 64'd0);
        chk("rst_xfer_cnt", 64'(a_cnt), 64'd0);

        rst_n = 1'b1;
        for (int v = 0; v < 14; v++) begin
            s_valid = tbl[v].valid;
            m_ready = tbl[v].mrdy;
            #1;
            chk($sformatf("vec%0d_s_ready_a", v), 64'(a_s_ready), 64'(tbl[v].exp_ready));
            chk($sformatf("vec%0d_s_ready_b", v), 64'(b_s_ready), 64'(tbl[v].exp_ready));
            tick();
            chk($sformatf("vec%0d_m_valid", v), 64'(a_m_valid), 64'(tbl[v].exp_mvalid));
            if (tbl[v].exp_mvalid) begin
                chk($sformatf("vec%0d_m_src", v), 64'(a_m_src), 64'(tbl[v].exp_src));
                chk($sformatf("vec%0d_m_data", v), 64'(a_m_data),
                    64'(32'hA5A5_0000 | 32'(tbl[v].exp_src)));
            end
            chk($sformatf("vec%0d_xfer_cnt", v), 64'(a_cnt), 64'(tbl[v].exp_cnt));
            chk($sformatf("vec%0d_xfer_cnt_b", v), 64'(b_cnt), 64'(tbl[v].exp_cnt));
        end

        // Fairness across all 15 children, then 4-bit counter wrap at 17 transfers.
        do_reset();
        s_valid = '1;
        for (int k = 0; k < 17; k++) begin
            tick();
            chk($sformatf("fair%0d_m_valid", k), 64'(a_m_valid), 64'd1);
            chk($sformatf("fair%0d_m_src", k), 64'(a_m_src), 64'(k % 15));
            chk($sformatf("fair%0d_xfer_cnt", k), 64'(a_cnt), 64'(k % 16));
        end
        s_valid = '0;
        tick();
        chk("wrap_xfer_cnt", 64'(a_cnt), 64'd1);
        chk("wrap_m_valid", 64'(a_m_valid), 64'd0);

        // Lock: child 2 sends 3 beats (with a bubble) while child 5 waits.
        do_reset();
        s_valid = 15'h0024;
        s_last  = '0;
        #1;
        chk("lock_c0_s_ready", 64'(b_s_ready), 64'h0004);
        tick();
        chk("lock_c0_m_src", 64'(b_m_src), 64'd2);
        chk("lock_c0_m_last", 64'(b_m_last), 64'd0);
        chk("lock_c0_m_data", 64'(b_m_data), 64'hA5A5_0002);
        s_valid = 15'h0020;
        #1;
        chk("lock_bubble_s_ready", 64'(b_s_ready), 64'h0004);
        tick();
        chk("lock_bubble_m_valid", 64'(b_m_valid), 64'd0);
        s_valid = 15'h0024;
        #1;
        chk("lock_c1_s_ready", 64'(b_s_ready), 64'h0004);
        tick();
        chk("lock_c1_m_src", 64'(b_m_src), 64'd2);
        s_last = 15'h0004;
        #1;
        chk("lock_c2_s_ready", 64'(b_s_ready), 64'h0004);
        tick();
        chk("lock_c2_m_src", 64'(b_m_src), 64'd2);
        chk("lock_c2_m_last", 64'(b_m_last), 64'd1);
        s_valid = 15'h0020;
        s_last  = '1;
        #1;
        chk("lock_c3_s_ready", 64'(b_s_ready), 64'h0020);
        tick();
        chk("lock_c3_m_src", 64'(b_m_src), 64'd5);
        s_valid = '0;
        tick();
        chk("lock_end_m_valid", 64'(b_m_valid), 64'd0);
        chk("lock_end_xfer_cnt", 64'(b_cnt), 64'd4);

        // Reset while child 7 holds the lock mid-packet.
        do_reset();
        s_valid = 15'h0280;
        s_last  = '0;
        #1;
        chk("rmid_s_ready", 64'(b_s_ready), 64'h0080);
        tick();
        chk("rmid_m_src", 64'(b_m_src), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("rmid_rst_s_ready_b", 64'(b_s_ready), 64'd0);
        chk("rmid_rst_s_ready_a", 64'(a_s_ready), 64'd0);
        tick();
        chk("rmid_m_valid", 64'(b_m_valid), 64'd0);
        chk("rmid_xfer_cnt", 64'(b_cnt), 64'd0);
        rst_n   = 1'b1;
        s_valid = 15'h0204;
        #1;
        chk("rmid_regrant_s_ready", 64'(b_s_ready), 64'h0004);
        tick();
        chk("rmid_regrant_m_src", 64'(b_m_src), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
